// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: MEM-stage memory access controller. Issues the memory request,
// stalls the pipeline on a miss until completion or timeout, and reports load data and errors.
`default_nettype none

module mem_access_ctrl #(
    parameter int TIMEOUT = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        instValid,
    input  logic        memReadIn,
    input  logic        memWriteIn,
    input  logic [15:0] addrIn,
    input  logic [15:0] wdataIn,
    input  logic        memDone,
    input  logic        memErr,
    input  logic [15:0] memRdata,
    output logic        memEn,
    output logic        memWr,
    output logic [15:0] memAddr,
    output logic [15:0] memWdata,
    output logic        stallPipe,
    output logic        bubbleWb,
    output logic [15:0] rdataOut,
    output logic        errOut
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [5:0] TIMEOUT_LAST = 6'(TIMEOUT - 1);

    state_t      state, state_nxt;
    logic [5:0]  cnt, cnt_nxt;
    logic [15:0] hold_addr, hold_addr_nxt;
    logic [15:0] hold_wdata, hold_wdata_nxt;
    logic        hold_wr, hold_wr_nxt;
    logic [15:0] res_data, res_data_nxt;
    logic        res_err, res_err_nxt;

    logic access;
    assign access = instValid & (memReadIn | memWriteIn);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            cnt        <= '0;
            hold_addr  <= '0;
            hold_wdata <= '0;
            hold_wr    <= 1'b0;
            res_data   <= '0;
            res_err    <= 1'b0;
        end else begin
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            hold_addr  <= hold_addr_nxt;
            hold_wdata <= hold_wdata_nxt;
            hold_wr    <= hold_wr_nxt;
            res_data   <= res_data_nxt;
            res_err    <= res_err_nxt;
        end
    end

    // Everything is gated by rst so outputs fall to zero asynchronously,
    // including the combinational IDLE request path.
    always_comb begin
        state_nxt      = state;
        cnt_nxt        = cnt;
        hold_addr_nxt  = hold_addr;
        hold_wdata_nxt = hold_wdata;
        hold_wr_nxt    = hold_wr;
        res_data_nxt   = res_data;
        res_err_nxt    = res_err;
        memEn          = 1'b0;
        memWr          = 1'b0;
        memAddr        = '0;
        memWdata       = '0;
        stallPipe      = 1'b0;
        bubbleWb       = 1'b0;
        rdataOut       = '0;
        errOut         = 1'b0;

        if (rst) begin
            case (state)
                IDLE: begin
                    if (access) begin
                        if (addrIn[0]) begin
                            errOut = 1'b1;
                        end else begin
                            memEn    = 1'b1;
                            memAddr  = addrIn;
                            memWdata = wdataIn;
                            memWr    = memWriteIn;
                            if (memDone) begin
                                rdataOut = memWriteIn ? 16'h0000 : memRdata;
                                errOut   = memErr;
                            end else begin
                                stallPipe      = 1'b1;
                                bubbleWb       = 1'b1;
                                hold_addr_nxt  = addrIn;
                                hold_wdata_nxt = wdataIn;
                                hold_wr_nxt    = memWriteIn;
                                cnt_nxt        = '0;
                                state_nxt      = WAIT;
                            end
                        end
                    end
                end
                WAIT: begin
                    memAddr   = hold_addr;
                    memWdata  = hold_wdata;
                    memWr     = hold_wr;
                    stallPipe = 1'b1;
                    bubbleWb  = 1'b1;
                    // A completion in the timeout cycle still carries the real result.
                    if (memDone) begin
                        res_data_nxt = hold_wr ? 16'h0000 : memRdata;
                        res_err_nxt  = memErr;
                        state_nxt    = DONE;
                    end else if (cnt == TIMEOUT_LAST) begin
                        res_data_nxt = 16'h0000;
                        res_err_nxt  = 1'b1;
                        state_nxt    = DONE;
                    end else begin
                        cnt_nxt = cnt + 6'd1;
                    end
                end
                DONE: begin
                    rdataOut  = res_data;
                    errOut    = res_err;
                    state_nxt = IDLE;
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_mem_access_ctrl.sv
// tb_mem_access_ctrl: directed scenarios plus randomized traffic, checked each cycle
// against a transaction-level model of the access controller.
`default_nettype none

module tb_mem_access_ctrl;

    localparam int TO = 32;

    logic        clk = 1'b0;
    logic        rst, instValid, memReadIn, memWriteIn, memDone, memErr;
    logic [15:0] addrIn, wdataIn, memRdata;
    logic        memEn, memWr, stallPipe, bubbleWb, errOut;
    logic [15:0] memAddr, memWdata, rdataOut;

    int n_checks = 0;
    int n_fail   = 0;
    int stall_tally;

    // Model: an outstanding access, how many WAIT cycles it has spent, and a result to deliver.
    bit          m_busy, m_res, m_hwr, m_err;
    int          m_waited;
    logic [15:0] m_haddr, m_hwd, m_rdata;

    mem_access_ctrl #(.TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .instValid(instValid), .memReadIn(memReadIn),
        .memWriteIn(memWriteIn), .addrIn(addrIn), .wdataIn(wdataIn),
        .memDone(memDone), .memErr(memErr), .memRdata(memRdata),
        .memEn(memEn), .memWr(memWr), .memAddr(memAddr), .memWdata(memWdata),
        .stallPipe(stallPipe), .bubbleWb(bubbleWb), .rdataOut(rdataOut), .errOut(errOut)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %h expected %h", tag, $time, got, exp);
        end
    endtask

    task automatic step(input logic r, input logic iv, input logic rd, input logic wr,
                        input logic [15:0] a, input logic [15:0] wd,
                        input logic dn, input logic er, input logic [15:0] rdat);
        logic        e_en, e_wr, e_st, e_bb, e_err, chk_bus, acc;
        logic [15:0] e_addr, e_wd, e_rd;
        @(negedge clk);
        rst = r; instValid = iv; memReadIn = rd; memWriteIn = wr;
        addrIn = a; wdataIn = wd; memDone = dn; memErr = er; memRdata = rdat;
        #1;
        e_en = 0; e_wr = 0; e_st = 0; e_bb = 0; e_err = 0;
        e_addr = '0; e_wd = '0; e_rd = '0; chk_bus = 1;
        if (!r) begin
            m_busy = 0; m_res = 0; m_waited = 0;
        end else if (m_res) begin
            e_rd = m_rdata; e_err = m_err; chk_bus = 0;
            m_res = 0;
        end else if (m_busy) begin
            e_st = 1; e_bb = 1; e_addr = m_haddr; e_wd = m_hwd; e_wr = m_hwr;
            if (dn) begin
                m_res = 1; m_busy = 0; m_rdata = m_hwr ? 16'h0 : rdat; m_err = er;
            end else if (m_waited + 1 == TO) begin
                m_res = 1; m_busy = 0; m_rdata = 16'h0; m_err = 1;
            end else begin
                m_waited++;
            end
        end else begin
            acc = iv & (rd | wr);
            if (!acc) begin
                chk_bus = 0;
            end else if (a[0]) begin
                e_err = 1; chk_bus = 0;
            end else begin
                e_en = 1; e_addr = a; e_wd = wd; e_wr = wr;
                if (dn) begin
                    e_rd = wr ? 16'h0 : rdat; e_err = er;
                end else begin
                    e_st = 1; e_bb = 1;
                    m_busy = 1; m_waited = 0; m_haddr = a; m_hwd = wd; m_hwr = wr;
                end
            end
        end
        check_val("memEn", 32'(memEn), 32'(e_en));
        check_val("stallPipe", 32'(stallPipe), 32'(e_st));
        check_val("bubbleWb", 32'(bubbleWb), 32'(e_bb));
        check_val("rdataOut", 32'(rdataOut), 32'(e_rd));
        check_val("errOut", 32'(errOut), 32'(e_err));
        if (chk_bus) begin
            check_val("memAddr", 32'(memAddr), 32'(e_addr));
            check_val("memWdata", 32'(memWdata), 32'(e_wd));
            check_val("memWr", 32'(memWr), 32'(e_wr));
        end
        if (stallPipe) stall_tally++;
    endtask

    task automatic idle_step(input logic dn);
        step(1, 0, 0, 0, 16'h0, 16'h0, dn, 0, 16'hFFFF);
    endtask

    initial begin
        int          pct;
        logic [15:0] a;
        rst = 0; instValid = 0; memReadIn = 0; memWriteIn = 0;
        addrIn = 0; wdataIn = 0; memDone = 0; memErr = 0; memRdata = 0;
        m_busy = 0; m_res = 0; m_waited = 0; m_hwr = 0; m_err = 0;
        m_haddr = 0; m_hwd = 0; m_rdata = 0;

        // Reset holds outputs at zero even with a live request on the inputs.
        step(0, 1, 1, 0, 16'h0010, 16'h1111, 1, 1, 16'hBEEF);
        step(0, 0, 0, 0, 16'h0, 16'h0, 0, 0, 16'h0);

        // Zero-latency hit.
        step(1, 1, 1, 0, 16'h0010, 16'h0, 1, 0, 16'hBEEF);
        idle_step(0);

        // Miss with three WAIT cycles; DONE ignores a new request.
        stall_tally = 0;
        step(1, 1, 1, 0, 16'h0020, 16'h0, 0, 0, 16'h0);
        step(1, 1, 0, 1, 16'h9990, 16'h7777, 0, 0, 16'h0);
        step(1, 0, 0, 0, 16'h0, 16'h0, 0, 0, 16'h0);
        step(1, 0, 0, 0, 16'h0, 16'h0, 1, 0, 16'h1234);
        step(1, 1, 1, 0, 16'h0060, 16'h0, 1, 1, 16'hDEAD);
        check_val("miss_stall_cycles", 32'(stall_tally), 32'd4);
        idle_step(1);

        // Unaligned store.
        step(1, 1, 0, 1, 16'h0031, 16'h5555, 0, 0, 16'h0);

        // Timeout.
        stall_tally = 0;
        step(1, 1, 1, 0, 16'h0040, 16'h0, 0, 0, 16'h0);
        for (int i = 0; i < TO; i++) idle_step(0);
        idle_step(0);
        check_val("timeout_stall_cycles", 32'(stall_tally), 32'(TO + 1));
        idle_step(0);

        // Reset during WAIT aborts; later memDone is ignored.
        step(1, 1, 0, 1, 16'h0050, 16'hA5A5, 0, 0, 16'h0);
        idle_step(0);
        step(0, 0, 0, 0, 16'h0, 16'h0, 0, 0, 16'h0);
        step(0, 0, 0, 0, 16'h0, 16'h0, 1, 1, 16'h4321);
        idle_step(1);
        idle_step(0);

        // memDone coincides with the timeout cycle.
        step(1, 1, 1, 0, 16'h0070, 16'h0, 0, 0, 16'h0);
        for (int i = 0; i < TO - 1; i++) idle_step(0);
        step(1, 0, 0, 0, 16'h0, 16'h0, 1, 0, 16'h5A5A);
        idle_step(0);

        // Randomized traffic with varying memory responsiveness.
        pct = 50;
        for (int c = 0; c < 4000; c++) begin
            if (c % 64 == 0) begin
                case ($urandom_range(3))
                    0:       pct = 0;
                    1:       pct = 15;
                    2:       pct = 50;
                    default: pct = 100;
                endcase
            end
            a = 16'($urandom);
            if ($urandom_range(3) != 0) a[0] = 1'b0;
            step(($urandom_range(199) != 0), ($urandom_range(3) != 0),
                 1'($urandom), 1'($urandom), a, 16'($urandom),
                 (int'($urandom_range(99)) < pct), 1'($urandom), 16'($urandom));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/mem_access_ctrl.md
MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

Interface
REQ-001 Parameter: TIMEOUT, default 32, max WAIT cycles before an access is aborted with error; legal range 2..63.
REQ-002 Port: clk  in  1  sole clock; all state updates on its rising edge.
REQ-003 Port: rst  in  1  reset, asynchronous, active-low (0 = reset asserted).
REQ-004 Port: instValid  in  1  EX/MEM stage holds a valid instruction.
REQ-005 Port: memReadIn / memWriteIn  in  1 each  EX/MEM control, load / store request.
REQ-006 Port: addrIn  in  16  byte address from EX/MEM ALU result.
REQ-007 Port: wdataIn  in  16  store data.
REQ-008 Port: memDone / memErr  in  1 each  memory completion strobe; error qualifier valid with memDone.
REQ-009 Port: memRdata  in  16  read data, valid with memDone.
REQ-010 Port: memEn / memWr  out  1 each  memory request strobe; 1 = write.
REQ-011 Port: memAddr / memWdata  out  16 each  address / write data to memory.
REQ-012 Port: stallPipe  out  1  freezes PC, IF/ID, ID/EX, EX/MEM registers.
REQ-013 Port: bubbleWb  out  1  forces MEM/WB RegWrite, MemRead, writeRegValid inputs to 0.
REQ-014 Port: rdataOut  out  16  load data to MEM/WB memData input.
REQ-015 Port: errOut  out  1  access error to MEM/WB errIn2.

Function
REQ-016 Access = instValid & (memReadIn | memWriteIn); memWriteIn takes priority if both set (memWr=1).
REQ-017 States: IDLE, WAIT, DONE; 2-bit encoded; 6-bit wait counter.
REQ-018 IDLE, no access: memEn=0, stallPipe=0, bubbleWb=0, errOut=0, rdataOut=0; memDone ignored.
REQ-019 IDLE, access with addrIn[0]=1 (unaligned): memEn=0, errOut=1 same cycle, no stall, stay IDLE.
REQ-020 IDLE, aligned access: memEn=1, memAddr=addrIn, memWdata=wdataIn, memWr per REQ-016, combinationally same cycle.
REQ-021 IDLE, aligned access with memDone=1 same cycle: zero-latency hit; rdataOut=memRdata, errOut=memErr, stallPipe=0, stay IDLE.
REQ-022 IDLE, aligned access with memDone=0: stallPipe=1, bubbleWb=1; latch addr, wdata, wr into hold registers; counter cleared; next state WAIT.
REQ-023 WAIT: memEn=0; memAddr/memWdata/memWr driven from hold registers; stallPipe=1, bubbleWb=1; request inputs ignored.
REQ-024 WAIT, memDone=1: latch memRdata and memErr; next state DONE.
REQ-025 WAIT, memDone=0: counter increments; when counter = TIMEOUT-1, latch rdata=0, err=1, next state DONE.
REQ-026 WAIT, memDone and timeout same cycle: memDone wins, err = memErr.
REQ-027 DONE (exactly one cycle): stallPipe=0, bubbleWb=0, memEn=0, rdataOut=latched data, errOut=latched err; EX/MEM request ignored; next state IDLE.
REQ-028 Miss latency: stall cycles = 1 (IDLE) + number of WAIT cycles before memDone; one DONE cycle releases.
REQ-029 Stores: rdataOut=0 in every state for write accesses.
REQ-030 memDone arriving in DONE or in IDLE without access is ignored; no state change.

Reset
REQ-031 While rst=0: state=IDLE, counter=0, hold and latched registers=0; all outputs 0, regardless of clk.
REQ-032 rst asserted during WAIT aborts the access immediately: stallPipe and bubbleWb drop to 0 asynchronously; no DONE cycle.
REQ-033 First edge after rst deasserts samples inputs under IDLE rules.

Verification
REQ-034 Aligned load 0x0010, memDone same cycle, memRdata=0xBEEF -> memEn=1, stallPipe=0, rdataOut=0xBEEF, state stays IDLE.
REQ-035 Load 0x0020, memDone after 3 WAIT cycles with 0x1234 -> stallPipe=1 for 4 cycles, memEn=1 only first cycle, DONE cycle rdataOut=0x1234, errOut=0.
REQ-036 Store 0x0031 (unaligned) -> memEn=0, errOut=1 same cycle, stallPipe=0.
REQ-037 Load 0x0040, memDone never -> after TIMEOUT WAIT cycles (32) DONE with errOut=1, rdataOut=0x0000, then IDLE.
REQ-038 Store 0x0050 data 0xA5A5, rst=0 in 2nd WAIT cycle -> stallPipe=0 immediately, all outputs 0, later memDone ignored.
REQ-039 memDone and timeout coincide with memErr=0 -> DONE errOut=0, rdataOut=memRdata.
